// File: rtl/panel_pkg.sv
// rtl/panel_pkg.sv - shared constants, address/pixel field positions and FSM states
// for the LED panel frame loader.
package panel_pkg;

  localparam int PANEL_COLS = 96;
  localparam int PANEL_ROWS = 32;

  localparam int BUF_BIT    = 13;
  localparam int COL7_BIT   = 12;
  localparam int ROW4_BIT   = 11;
  localparam int ROW_LO_MSB = 10;
  localparam int ROW_LO_LSB = 7;
  localparam int COL_LO_MSB = 6;
  localparam int COL_LO_LSB = 0;

  localparam int PIX_R_MSB = 11;
  localparam int PIX_R_LSB = 8;
  localparam int PIX_G_MSB = 7;
  localparam int PIX_G_LSB = 4;
  localparam int PIX_B_MSB = 3;
  localparam int PIX_B_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SWAP = 2'd2
  } state_t;

  // The driver's bank layout splits col[7] and row[4] above the low row/col fields.
  function automatic logic [13:0] make_addr(input logic bsel, input logic [4:0] row,
                                            input logic [7:0] col);
    logic [13:0] a;
    a = '0;
    a[BUF_BIT]                 = bsel;
    a[COL7_BIT]                = col[7];
    a[ROW4_BIT]                = row[4];
    a[ROW_LO_MSB:ROW_LO_LSB]   = row[3:0];
    a[COL_LO_MSB:COL_LO_LSB]   = col[6:0];
    return a;
  endfunction

endpackage

// File: rtl/byte_pixel_packer.sv
// rtl/byte_pixel_packer.sv - 3-byte to 2-pixel RGB444 gearbox.
// sync_reset together with accept treats the current byte as phase 0.
module byte_pixel_packer
  import panel_pkg::*;
(
  input  logic        clk,
  input  logic        sync_reset,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic [11:0] pixel,
  output logic        pixel_valid
);

  logic [1:0] phase_q;
  logic [7:0] b0_q;
  logic [3:0] nib_q;

  always_comb begin
    pixel       = '0;
    pixel_valid = accept && !sync_reset && (phase_q != 2'd0);
    if (phase_q == 2'd1) begin
      pixel[PIX_R_MSB:PIX_R_LSB] = b0_q[7:4];
      pixel[PIX_G_MSB:PIX_G_LSB] = b0_q[3:0];
      pixel[PIX_B_MSB:PIX_B_LSB] = data[7:4];
    end else begin
      pixel[PIX_R_MSB:PIX_R_LSB] = nib_q;
      pixel[PIX_G_MSB:PIX_G_LSB] = data[7:4];
      pixel[PIX_B_MSB:PIX_B_LSB] = data[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (sync_reset) begin
      phase_q <= accept ? 2'd1 : 2'd0;
      if (accept) b0_q <= data;
    end else if (accept) begin
      case (phase_q)
        2'd0: begin
          b0_q    <= data;
          phase_q <= 2'd1;
        end
        2'd1: begin
          nib_q   <= data[3:0];
          phase_q <= 2'd2;
        end
        default: phase_q <= 2'd0;
      endcase
    end
  end

endmodule

// File: rtl/frame_loader.sv
// rtl/frame_loader.sv - unpacks a host byte stream into RGB444 pixels, writes them
// into the panel driver's back framebuffer and hands off the buffer at end of frame.
module frame_loader
  import panel_pkg::*;
#(
  parameter int COLS = PANEL_COLS,
  parameter int ROWS = PANEL_ROWS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_sof,
  output logic        wr,
  output logic [13:0] wr_addr,
  output logic [11:0] wr_data,
  output logic        buffer_select,
  input  logic        buffer_current,
  output logic        frame_done,
  output logic        busy
);

  localparam logic [7:0] COL_LAST = 8'(COLS - 1);
  localparam logic [4:0] ROW_LAST = 5'(ROWS - 1);

  state_t      state_q, state_d;
  logic        back_q;
  logic        swap_first_q;
  logic [4:0]  row_q;
  logic [7:0]  col_q;

  logic        hs, sof_hs, frame_byte;
  logic        pk_accept, pk_sync;
  logic [11:0] pixel;
  logic        pix_valid;
  logic        last_pix;

  assign hs         = in_valid && in_ready;
  assign sof_hs     = hs && in_sof;
  assign frame_byte = hs && ((state_q == LOAD) || in_sof);
  assign pk_accept  = rst_n && frame_byte;
  assign pk_sync    = !rst_n || sof_hs;
  assign last_pix   = pix_valid && (row_q == ROW_LAST) && (col_q == COL_LAST);

  byte_pixel_packer u_packer (
    .clk         (clk),
    .sync_reset  (pk_sync),
    .accept      (pk_accept),
    .data        (in_data),
    .pixel       (pixel),
    .pixel_valid (pix_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // The first SWAP cycle only publishes the new buffer; the compare starts one cycle later.
  always_comb begin
    state_d    = state_q;
    in_ready   = 1'b1;
    busy       = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (sof_hs) state_d = LOAD;
      end
      LOAD: begin
        busy = 1'b1;
        if (last_pix) state_d = SWAP;
      end
      SWAP: begin
        in_ready = 1'b0;
        busy     = 1'b1;
        if (!swap_first_q && (buffer_current == buffer_select)) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr            <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      buffer_select <= 1'b0;
      back_q        <= 1'b0;
      swap_first_q  <= 1'b0;
      row_q         <= '0;
      col_q         <= '0;
    end else begin
      wr <= pix_valid;
      if (pix_valid) begin
        wr_addr <= make_addr(back_q, row_q, col_q);
        wr_data <= pixel;
      end

      if (sof_hs) begin
        row_q <= '0;
        col_q <= '0;
        if (state_q == IDLE) back_q <= ~buffer_select;
      end else if (pix_valid) begin
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= row_q + 5'd1;
        end else begin
          col_q <= col_q + 8'd1;
        end
      end

      swap_first_q <= (state_q == LOAD) && (state_d == SWAP);
      if ((state_q == SWAP) && swap_first_q) buffer_select <= back_q;
    end
  end

endmodule

// File: tb/tb_frame_loader.sv
// tb/tb_frame_loader.sv - directed self-checking bench for frame_loader.
module tb_frame_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_sof;
  logic        wr;
  logic [13:0] wr_addr;
  logic [11:0] wr_data;
  logic        buffer_select;
  logic        buffer_current;
  logic        frame_done;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  int gen = 1;
  int wr_count = 0;
  int dup_count = 0;
  int fd_count = 0;
  int seen_gen [16384];
  logic [11:0] mem [16384];

  always #5 clk = ~clk;

  frame_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .in_sof         (in_sof),
    .wr             (wr),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .buffer_select  (buffer_select),
    .buffer_current (buffer_current),
    .frame_done     (frame_done),
    .busy           (busy)
  );

  always @(negedge clk) begin
    if (rst_n && wr) begin
      wr_count++;
      if (seen_gen[wr_addr] == gen) dup_count++;
      seen_gen[wr_addr] = gen;
      mem[wr_addr] = wr_data;
    end
    if (frame_done) fd_count++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic sof);
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  function automatic logic [11:0] exp_pix(input int i);
    if (i == 0) return 12'h123;
    if (i == 1) return 12'h456;
    return 12'(i);
  endfunction

  function automatic logic [13:0] addr_of(input logic b, input int row, input int col);
    logic [7:0] c;
    logic [4:0] r;
    c = 8'(col);
    r = 5'(row);
    return {b, c[7], r[4], r[3:0], c[6:0]};
  endfunction

  task automatic send_pair(input int k);
    logic [11:0] p0, p1;
    p0 = exp_pix(2 * k);
    p1 = exp_pix(2 * k + 1);
    send_byte(p0[11:4], 1'b0);
    send_byte({p0[3:0], p1[11:8]}, 1'b0);
    send_byte(p1[7:0], 1'b0);
  endtask

  initial begin
    int base, dbase, fdb, bad, errs, sent;
    logic [11:0] p0, p1;
    logic [13:0] a;

    rst_n = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h55;
    in_sof = 1'b0;
    buffer_current = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_wr", wr, 0);
    check("reset_bsel", buffer_select, 0);
    check("reset_busy", busy, 0);
    check("reset_ready", in_ready, 1);
    check("reset_done", frame_done, 0);
    check("reset_addr", wr_addr, 0);
    check("reset_data", wr_data, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;

    base = wr_count;
    for (int i = 0; i < 5; i++) send_byte(8'(i * 37 + 1), 1'b0);
    tick(2);
    check("idle_no_wr", wr_count - base, 0);
    check("idle_busy", busy, 0);

    send_byte(8'hAB, 1'b1);
    check("sof_busy", busy, 1);
    check("sof_no_wr", wr, 0);
    send_byte(8'hCD, 1'b0);
    check("pk0_wr", wr, 1);
    check("pk0_addr", wr_addr, 14'h2000);
    check("pk0_data", wr_data, 12'hABC);
    send_byte(8'hEF, 1'b0);
    check("pk1_wr", wr, 1);
    check("pk1_addr", wr_addr, 14'h2001);
    check("pk1_data", wr_data, 12'hDEF);
    for (int i = 0; i < 97; i++) send_byte(8'(i), 1'b0);

    gen++;
    base = wr_count;
    dbase = dup_count;
    send_byte(8'h12, 1'b1);
    check("rs_no_wr", wr, 0);
    send_byte(8'h34, 1'b0);
    check("rs0_addr", wr_addr, 14'h2000);
    check("rs0_data", wr_data, 12'h123);
    send_byte(8'h56, 1'b0);
    check("rs1_addr", wr_addr, 14'h2001);
    check("rs1_data", wr_data, 12'h456);
    for (int k = 1; k < 1535; k++) send_pair(k);

    p0 = exp_pix(3070);
    p1 = exp_pix(3071);
    send_byte(p0[11:4], 1'b0);
    send_byte({p0[3:0], p1[11:8]}, 1'b0);
    check("pre_last_ready", in_ready, 1);
    send_byte(p1[7:0], 1'b0);
    check("last_wr", wr, 1);
    check("last_addr", wr_addr, 14'h2FDF);
    check("last_data", wr_data, 12'hBFF);
    check("last_ready", in_ready, 0);
    check("last_bsel", buffer_select, 0);
    tick(1);
    check("bsel_rise", buffer_select, 1);
    check("frame_writes", wr_count - base, 3072);
    check("frame_dups", dup_count - dbase, 0);
    check("map_r17c5", mem[14'h2885], 12'h665);
    errs = 0;
    for (int idx = 0; idx < 3072; idx++) begin
      a = addr_of(1'b1, idx / 96, idx % 96);
      if (seen_gen[a] != gen || mem[a] !== exp_pix(idx)) errs++;
    end
    check("frame_data", errs, 0);

    bad = 0;
    fdb = fd_count;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (in_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    check("swap_hold", bad, 0);
    check("swap_no_done", fd_count - fdb, 0);
    buffer_current = 1'b1;
    #1;
    check("done_pulse", frame_done, 1);
    tick(10);
    check("done_once", fd_count - fdb, 1);
    check("post_busy", busy, 0);
    check("post_ready", in_ready, 1);

    gen++;
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b0);
    check("nf_wr", wr, 1);
    check("nf_addr", wr_addr, 14'h0000);
    sent = 2;
    while (sent < 2000) begin
      send_byte(8'(sent), 1'b0);
      sent++;
    end
    check("pre_rst_wr", wr, 1);
    rst_n = 1'b0;
    tick(1);
    check("rst_wr", wr, 0);
    check("rst_bsel", buffer_select, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b0);
    check("fr0_addr", wr_addr, 14'h2000);
    check("fr0_data", wr_data, 12'hABC);
    send_byte(8'hEF, 1'b0);
    check("fr1_addr", wr_addr, 14'h2001);
    check("fr1_data", wr_data, 12'hDEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_loader.md
Name: frame_loader

Overview:
- Upstream feeder for the 96x32 LED panel driver. It takes a host byte stream (from the UART/SPI bridge) and unpacks 12-bit RGB444 pixels from it.
- It writes each pixel into the driver's back framebuffer through the driver's write port.
- At end of frame it flips buffer_select and holds off new data until the driver reports the swap via buffer_current.
- It runs on the driver's write clock domain, so wr_clk of the driver is tied to clk here.

Parameters:
- COLS, 96, pixels per row; legal range 1..256, maps to col[7:0].
- ROWS, 32, rows per frame; fixed 32, maps to row[4:0].

Ports:
- clk  in  1  system clock; the driver's wr_clk.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  byte-stream valid.
- in_ready  out  1  byte-stream ready; a byte is accepted when in_valid && in_ready.
- in_data  in  8  stream byte.
- in_sof  in  1  start-of-frame, qualified with in_valid; marks the first byte of a frame.
- wr  out  1  framebuffer write strobe, one cycle per pixel.
- wr_addr  out  14  {buf, col[7], row[4], row[3:0], col[6:0]}.
- wr_data  out  12  {r[3:0], g[3:0], b[3:0]}.
- buffer_select  out  1  buffer the driver displays from its next frame wrap.
- buffer_current  in  1  buffer the driver is currently displaying.
- frame_done  out  1  one-cycle pulse when a swap completes.
- busy  out  1  high in LOAD and SWAP.

Behaviour:
- Reset (rst_n low at a clk edge) forces the following; this applies equally mid-frame, and any partial frame is discarded:
  - wr=0, wr_addr=0, wr_data=0, buffer_select=0, frame_done=0.
  - state=IDLE, in_ready=1, counters and byte phase cleared.
- back = ~buffer_select, sampled at the start of LOAD; wr_addr[13] = back for the whole frame.
- States:
  - IDLE: in_ready=1. Bytes without in_sof are accepted and dropped. A byte with in_sof starts a frame: it is processed as byte phase 0, row=col=0, then state goes to LOAD.
  - LOAD: in_ready=1.
  - SWAP: in_ready=0.
- Packing, 3 bytes to 2 pixels, byte phase cycles 0,1,2:
  - Phase 0: hold B0.
  - Phase 1: pixel P0 = {B0, B1[7:4]} is written; hold B1[3:0].
  - Phase 2: pixel P1 = {B1[3:0], B2} is written.
- Write latency: wr, wr_addr and wr_data are registered. wr is high in the cycle after the accepting handshake of phase-1 and phase-2 bytes. At most one write occurs per cycle.
- Raster order:
  - col increments after each pixel. At col==COLS-1 it wraps to 0 and row increments.
  - A pixel at row==ROWS-1, col==COLS-1 is the last pixel: 3072 pixels / 4608 bytes at the defaults.
- in_sof in LOAD restarts the frame: counters and phase reset, and the byte is treated as phase 0. Writes already issued are not undone. back is unchanged.
- After the wr of the last pixel, enter SWAP:
  - On the first SWAP cycle, buffer_select <= back.
  - Remain in SWAP until buffer_current == buffer_select. That cycle: frame_done=1, then go to IDLE.
  - No timeout; the wait can be one full driver refresh or more.
- Odd trailing bytes are impossible because the frame is an even pixel count at the defaults. If COLS*ROWS is odd, the final phase-1 byte completes the frame and its low nibble is ignored.
- Backpressure: when in_valid=0 in any state, nothing changes except the SWAP wait.

Decomposition:
- Shared package (panel_pkg), holding:
  - constants PANEL_COLS=96 and PANEL_ROWS=32;
  - wr_addr field positions (BUF_BIT=13, COL7_BIT=12, ROW4_BIT=11, ROW_LO=10:7, COL_LO=6:0);
  - pixel field positions (R=11:8, G=7:4, B=3:0);
  - the state enum (IDLE, LOAD, SWAP).
- One sub-module, byte_pixel_packer: the 3-to-2 gearbox, with a phase counter, an output pixel and a pixel_valid. Its inputs are the byte, accept, and sync_reset (from sof/reset).

Test Plan:
- Reset values: hold rst_n=0 for 3 cycles with in_valid=1 -> wr=0, buffer_select=0, busy=0, in_ready=1; release and send 5 bytes without sof -> no wr, state stays IDLE.
- Pack and address: send sof+bytes 0xAB,0xCD,0xEF -> write 0xABC at wr_addr 0x2000, then 0xDEF at 0x2001, each one cycle after its byte.
- Mapping: a full frame of incrementing pixels, with a scoreboard keyed on wr_addr:
  - row 17 col 5 -> wr_addr 0x2885;
  - 3072 writes total;
  - no duplicate addresses;
  - buffer_select rises 1 cycle after the last wr.
- Swap wait: hold buffer_current=0 for 1000 cycles after the frame -> in_ready=0 and busy=1 throughout. Set buffer_current=1 -> frame_done pulses once, then IDLE. The next frame writes with wr_addr[13]=0.
- Mid-frame restart: after 100 bytes send sof+0x12,0x34,0x56 -> write 0x123 at the base address (row 0 col 0) and 0x456 at base+1; the frame completes only after 4608 bytes counted from the restart.
- Reset mid-LOAD: assert rst_n=0 after 2000 bytes -> wr=0 next edge and buffer_select=0; a fresh frame writes with wr_addr[13]=1 starting at row 0 col 0.
